// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tile batch sequencer and the tile it drives.
package tile_sched_pkg;

  localparam int unsigned OUTPUT_SZ = 10;
  localparam logic signed [31:0] FIXED_1 = 32'sh0001_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_RUN,
    S_SCORE,
    S_NEXT,
    S_FINISH
  } sched_state_t;

endpackage

// File: rtl/tile_sched_if.sv
// Fetch port (image store) and tile control/result port seen by the sequencer.
interface tile_sched_if #(
  parameter int unsigned IDX_W     = 16,
  parameter int unsigned OUTPUT_SZ = tile_sched_pkg::OUTPUT_SZ
);
  logic                        img_req;
  logic [IDX_W-1:0]            img_addr;
  logic                        img_ack;
  logic [7:0]                  img_label;
  logic                        tile_start_fp;
  logic                        tile_start_bp;
  logic [7:0]                  tile_label;
  logic                        tile_done;
  logic [OUTPUT_SZ-1:0][31:0]  tile_result;

  modport master (
    output img_req, img_addr, tile_start_fp, tile_start_bp, tile_label,
    input  img_ack, img_label, tile_done, tile_result
  );

  modport slave (
    input  img_req, img_addr, tile_start_fp, tile_start_bp, tile_label,
    output img_ack, img_label, tile_done, tile_result
  );
endinterface

// File: rtl/tile_sched_argmax_serial.sv
// Serial signed argmax over a registered snapshot of the tile outputs.
module argmax_serial #(
  parameter  int unsigned OUTPUT_SZ = tile_sched_pkg::OUTPUT_SZ,
  localparam int unsigned KW        = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [OUTPUT_SZ-1:0][31:0] result,
  output logic                       valid,
  output logic [KW-1:0]              best_idx
);

  localparam logic [KW-1:0] K_LAST = KW'(OUTPUT_SZ - 1);

  logic [OUTPUT_SZ-1:0][31:0] snap_q, snap_d;
  logic [KW-1:0]              k_q, k_d;
  logic [KW-1:0]              best_idx_q, best_idx_d;
  logic signed [31:0]         best_q, best_d;
  logic                       active_q, active_d;
  logic signed [31:0]         cur;
  logic                       take;

  // Strictly-greater replacement keeps ties on the lowest index.
  assign cur      = snap_q[k_q];
  assign take     = (k_q == '0) || (cur > best_q);
  assign best_idx = take ? k_q : best_idx_q;
  assign valid    = active_q && (k_q == K_LAST);

  always_comb begin
    snap_d     = snap_q;
    k_d        = k_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    active_d   = active_q;
    if (load) begin
      snap_d   = result;
      k_d      = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (take) begin
        best_d     = cur;
        best_idx_d = k_q;
      end
      if (k_q == K_LAST) active_d = 1'b0;
      else               k_d      = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q     <= '0;
      k_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      active_q   <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      k_q        <= k_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      active_q   <= active_d;
    end
  end

endmodule

// File: rtl/tile_sched.sv
// Batch sequencer: fetch image/label, launch tile (fp or bp), watchdog, score argmax vs label.
module tile_sched #(
  parameter int unsigned OUTPUT_SZ   = tile_sched_pkg::OUTPUT_SZ,
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             train,
  input  logic [IDX_W-1:0] num_images,
  input  logic             abort,
  tile_sched_if.master     bus,
  output logic             busy,
  output logic             batch_done,
  output logic [IDX_W-1:0] correct_cnt,
  output logic [IDX_W-1:0] img_cnt,
  output logic             err_timeout
);
  import tile_sched_pkg::*;

  localparam int unsigned KW      = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  sched_state_t     state_q, state_d;
  logic             train_q, train_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] correct_q, correct_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       label_q, label_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic             score_load;
  logic             score_valid;
  logic [KW-1:0]    best_idx;
  logic             hit;

  // best_idx never reaches OUTPUT_SZ, so out-of-range labels cannot match.
  assign hit        = (8'(best_idx) == label_q);
  assign score_load = (state_q == S_RUN) && bus.tile_done && !abort;

  argmax_serial #(.OUTPUT_SZ(OUTPUT_SZ)) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .load     (score_load),
    .result   (bus.tile_result),
    .valid    (score_valid),
    .best_idx (best_idx)
  );

  assign bus.img_req       = (state_q == S_FETCH);
  assign bus.img_addr      = idx_q;
  assign bus.tile_start_fp = (state_q == S_START) && !abort && !train_q;
  assign bus.tile_start_bp = (state_q == S_START) && !abort &&  train_q;
  assign bus.tile_label    = label_q;
  assign busy              = (state_q != S_IDLE);
  assign batch_done        = (state_q == S_FINISH);
  assign correct_cnt       = correct_q;
  assign img_cnt           = cnt_q;
  assign err_timeout       = err_q;

  always_comb begin
    state_d   = state_q;
    train_d   = train_q;
    num_d     = num_q;
    idx_d     = idx_q;
    correct_d = correct_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    label_d   = label_q;
    wd_d      = wd_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          train_d   = train;
          num_d     = num_images;
          idx_d     = '0;
          correct_d = '0;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = (num_images == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) state_d = S_FINISH;
        else if (bus.img_ack) begin
          label_d = bus.img_label;
          state_d = S_START;
        end
      end
      S_START: begin
        if (abort) state_d = S_FINISH;
        else begin
          wd_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort)              state_d = S_FINISH;
        else if (bus.tile_done) state_d = S_SCORE;
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else wd_d = wd_q + 1'b1;
      end
      S_SCORE: begin
        if (abort) state_d = S_FINISH;
        else if (score_valid) begin
          if (hit && correct_q != '1) correct_d = correct_q + 1'b1;
          if (cnt_q != '1)            cnt_d     = cnt_q + 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort) state_d = S_FINISH;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q + 1'b1 == num_q) ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      train_q   <= 1'b0;
      num_q     <= '0;
      idx_q     <= '0;
      correct_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      label_q   <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      train_q   <= train_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      correct_q <= correct_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      label_q   <= label_d;
      wd_q      <= wd_d;
    end
  end

endmodule

// File: tb/tb_tile_sched.sv
// Directed bench for tile_sched: inference/training batches, ties, watchdog, abort, empty batch, async reset.
module tb_tile_sched;
  import tile_sched_pkg::*;

  localparam int unsigned IDX_W  = 16;
  localparam int unsigned TO_CYC = 16;

  typedef logic [OUTPUT_SZ-1:0][31:0] res_t;

  logic             clk;
  logic             rst;
  logic             go;
  logic             train;
  logic             abort;
  logic [IDX_W-1:0] num_images;
  logic             busy;
  logic             batch_done;
  logic [IDX_W-1:0] correct_cnt;
  logic [IDX_W-1:0] img_cnt;
  logic             err_timeout;

  int checks   = 0;
  int failures = 0;
  int n_fp     = 0;
  int n_bp     = 0;
  int n_done   = 0;
  int b_fp, b_bp, b_done;
  logic [IDX_W-1:0] exp_img, exp_cor;
  res_t tie_vec;

  tile_sched_if #(.IDX_W(IDX_W), .OUTPUT_SZ(OUTPUT_SZ)) bus ();

  tile_sched #(
    .OUTPUT_SZ   (OUTPUT_SZ),
    .IDX_W       (IDX_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .train       (train),
    .num_images  (num_images),
    .abort       (abort),
    .bus         (bus),
    .busy        (busy),
    .batch_done  (batch_done),
    .correct_cnt (correct_cnt),
    .img_cnt     (img_cnt),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tile_start_fp) n_fp++;
    if (bus.tile_start_bp) n_bp++;
    if (batch_done)        n_done++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // All entries negative except a positive peak at index p.
  function automatic res_t mk_peak(input int p);
    res_t r;
    for (int i = 0; i < int'(OUTPUT_SZ); i++) r[i] = 32'(-(i + 1) * int'(FIXED_1));
    r[p] = 32'(3 * int'(FIXED_1));
    return r;
  endfunction

  task automatic mark;
    b_fp   = n_fp;
    b_bp   = n_bp;
    b_done = n_done;
  endtask

  task automatic start_batch(input logic tr, input logic [IDX_W-1:0] n);
    go = 1'b1; train = tr; num_images = n;
    tick;
    go = 1'b0; train = ~tr; num_images = 16'd99;
    exp_img = '0; exp_cor = '0;
    check_eq("go_req", bus.img_req, (n != 0));
    check_eq("go_busy", busy, 1);
    check_eq("go_err_clr", err_timeout, 0);
  endtask

  task automatic wait_req;
    int unsigned n = 0;
    while (!bus.img_req && n < 50) begin tick; n++; end
    check_eq("req_seen", bus.img_req, 1);
  endtask

  task automatic launch(input logic [IDX_W-1:0] idx, input logic [7:0] label,
                        input int unsigned ack_dly, input logic bp);
    wait_req;
    check_eq("img_addr", bus.img_addr, idx);
    repeat (ack_dly) tick;
    bus.img_ack = 1'b1; bus.img_label = label;
    tick;
    bus.img_ack = 1'b0; bus.img_label = 8'hEE;
    check_eq("start_fp", bus.tile_start_fp, !bp);
    check_eq("start_bp", bus.tile_start_bp, bp);
    check_eq("tile_label", bus.tile_label, label);
    check_eq("req_drop", bus.img_req, 0);
  endtask

  task automatic score(input res_t res, input logic [7:0] label,
                       input int unsigned done_dly, input logic hit);
    repeat (done_dly) tick;
    check_eq("label_hold", bus.tile_label, label);
    bus.tile_result = res; bus.tile_done = 1'b1;
    tick;
    bus.tile_done = 1'b0; bus.tile_result = mk_peak(OUTPUT_SZ - 1);
    repeat (OUTPUT_SZ - 1) tick;
    check_eq("score_lat", img_cnt, exp_img);
    exp_img++;
    if (hit) exp_cor++;
    tick;
    check_eq("img_cnt", img_cnt, exp_img);
    check_eq("correct_cnt", correct_cnt, exp_cor);
  endtask

  task automatic end_batch;
    int unsigned n = 0;
    while (!batch_done && n < 20) begin tick; n++; end
    check_eq("batch_done", batch_done, 1);
    tick;
    check_eq("idle", busy, 0);
  endtask

  initial begin
    rst = 1'b0; go = 1'b0; train = 1'b0; abort = 1'b0; num_images = '0;
    bus.img_ack = 1'b0; bus.img_label = '0; bus.tile_done = 1'b0; bus.tile_result = '0;
    repeat (2) tick;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bdone", batch_done, 0);
    check_eq("rst_req", bus.img_req, 0);
    check_eq("rst_starts", {bus.tile_start_fp, bus.tile_start_bp}, 0);
    check_eq("rst_label", bus.tile_label, 0);
    check_eq("rst_cnts", {img_cnt, correct_cnt, err_timeout}, 0);
    rst = 1'b1;
    tick;

    // Inference: labels 4/7/1, peaks 4/2/1 -> 2 correct of 3
    mark;
    start_batch(1'b0, 16'd3);
    launch(16'd0, 8'd4, 2, 1'b0); score(mk_peak(4), 8'd4, 3, 1'b1);
    launch(16'd1, 8'd7, 2, 1'b0); score(mk_peak(2), 8'd7, 3, 1'b0);
    launch(16'd2, 8'd1, 2, 1'b0); score(mk_peak(1), 8'd1, 3, 1'b1);
    end_batch;
    check_eq("inf_fp", n_fp - b_fp, 3);
    check_eq("inf_bp", n_bp - b_bp, 0);
    check_eq("inf_done", n_done - b_done, 1);
    check_eq("inf_correct", correct_cnt, 2);
    check_eq("inf_imgs", img_cnt, 3);

    // Training: one image, one bp start
    mark;
    start_batch(1'b1, 16'd1);
    launch(16'd0, 8'd3, 0, 1'b1); score(mk_peak(3), 8'd3, 5, 1'b1);
    end_batch;
    check_eq("trn_fp", n_fp - b_fp, 0);
    check_eq("trn_bp", n_bp - b_bp, 1);

    // Ties and negatives: [-5, 9, 9, 0, ...] -> index 1
    tie_vec = '0;
    tie_vec[0] = 32'(-5 * int'(FIXED_1));
    tie_vec[1] = 32'(9 * int'(FIXED_1));
    tie_vec[2] = 32'(9 * int'(FIXED_1));
    start_batch(1'b0, 16'd2);
    launch(16'd0, 8'd1, 1, 1'b0); score(tie_vec, 8'd1, 2, 1'b1);
    launch(16'd1, 8'd2, 1, 1'b0); score(tie_vec, 8'd2, 2, 1'b0);
    end_batch;
    check_eq("tie_correct", correct_cnt, 1);

    // Out-of-range label never matches
    start_batch(1'b0, 16'd1);
    launch(16'd0, 8'd12, 0, 1'b0); score(mk_peak(2), 8'd12, 1, 1'b0);
    end_batch;

    // Watchdog: 16 RUN cycles without done
    mark;
    start_batch(1'b0, 16'd1);
    launch(16'd0, 8'd5, 0, 1'b0);
    repeat (TO_CYC) tick;
    check_eq("wd_pre_err", err_timeout, 0);
    check_eq("wd_pre_busy", busy, 1);
    tick;
    check_eq("wd_err", err_timeout, 1);
    check_eq("wd_bdone", batch_done, 1);
    check_eq("wd_imgs", img_cnt, 0);
    tick;
    check_eq("wd_idle", busy, 0);
    check_eq("wd_sticky", err_timeout, 1);

    // done on the last watchdog cycle still counts
    start_batch(1'b0, 16'd1);
    launch(16'd0, 8'd6, 0, 1'b0); score(mk_peak(6), 8'd6, TO_CYC, 1'b1);
    end_batch;
    check_eq("wd_edge_err", err_timeout, 0);

    // Abort during second fetch
    mark;
    start_batch(1'b0, 16'd3);
    launch(16'd0, 8'd2, 0, 1'b0); score(mk_peak(2), 8'd2, 1, 1'b1);
    wait_req;
    check_eq("abt_addr", bus.img_addr, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_eq("abt_req", bus.img_req, 0);
    check_eq("abt_bdone", batch_done, 1);
    check_eq("abt_imgs", img_cnt, 1);
    tick;
    check_eq("abt_idle", busy, 0);
    check_eq("abt_fp", n_fp - b_fp, 1);

    // Empty batch
    mark;
    start_batch(1'b0, 16'd0);
    check_eq("empty_bdone", batch_done, 1);
    tick;
    check_eq("empty_idle", busy, 0);
    check_eq("empty_fp", n_fp - b_fp, 0);

    // Async reset in RUN of the second image
    start_batch(1'b0, 16'd2);
    launch(16'd0, 8'd4, 1, 1'b0); score(mk_peak(4), 8'd4, 2, 1'b1);
    launch(16'd1, 8'd7, 0, 1'b0);
    tick; tick;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_req", bus.img_req, 0);
    check_eq("arst_label", bus.tile_label, 0);
    check_eq("arst_cnts", {img_cnt, correct_cnt, batch_done}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    start_batch(1'b0, 16'd1);
    launch(16'd0, 8'd1, 0, 1'b0); score(mk_peak(1), 8'd1, 2, 1'b1);
    end_batch;
    check_eq("post_rst_imgs", img_cnt, 1);
    check_eq("post_rst_correct", correct_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL sim_timeout: got expired, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
